password_entry_frontend: RTL

Keypad front end placed directly upstream of the password validator. It debounces the confirm button, latches the switch digit, and issues one `enable` strobe per accepted press. It also owns the 4-digit password store that the validator reads through `address`/`data`. While the validator reports unlocked, the store can be reprogrammed in an atomic four-press sequence.

---
 rtl/entry_pkg.sv | 14 +
 rtl/button_debouncer.sv | 50 +++++
 rtl/password_entry_frontend.sv | 116 +++++++++++
 3 files changed

// File: rtl/entry_pkg.sv
// rtl/entry_pkg.sv - shared types and sizes for the password entry front end
package entry_pkg;

    localparam int DIGIT_W         = 4;
    localparam int PASSWORD_DIGITS = 4;

    typedef logic [DIGIT_W-1:0] PasswordDigit;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PROGRAM = 1'b1
    } EntryState;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-flop synchronizer, stability counter and press-event register
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_in,
    output logic level,
    output logic pressEvent
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                // Any gap in the mismatch clears r_cnt, so only an unbroken run is accepted.
                if (r_cnt == LAST_CNT) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level      = r_level;
    assign pressEvent = r_press;

endmodule

// File: rtl/password_entry_frontend.sv
// rtl/password_entry_frontend.sv - keypad front end: digit latch, enable strobe, programmable password store
module password_entry_frontend
    import entry_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [15:0] RESET_PASSWORD  = 16'h1234
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] switches,
    input  logic       confirmBtn,
    input  logic       setMode,
    input  logic [1:0] address,
    input  logic       unlocked,
    output logic [3:0] digit,
    output logic [3:0] data,
    output logic       enable,
    output logic       programming,
    output logic [1:0] programIndex,
    output logic       programDone
);

    localparam logic [1:0] LAST_IDX = 2'(PASSWORD_DIGITS - 1);

    logic w_btn_level;
    logic w_press_event;
    logic w_press;

    EntryState    r_state;
    PasswordDigit r_store   [PASSWORD_DIGITS];
    PasswordDigit r_staging [PASSWORD_DIGITS];
    PasswordDigit r_digit;
    logic         r_enable;
    logic         r_programming;
    logic [1:0]   r_index;
    logic         r_done;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .CLK       (CLK),
        .RST       (RST),
        .btn_in    (confirmBtn),
        .level     (w_btn_level),
        .pressEvent(w_press_event)
    );

    assign w_press = w_press_event & w_btn_level;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_digit       <= '0;
            r_enable      <= 1'b0;
            r_programming <= 1'b0;
            r_index       <= '0;
            r_done        <= 1'b0;
            for (int k = 0; k < PASSWORD_DIGITS; k++) begin
                r_store[k]   <= RESET_PASSWORD[DIGIT_W*k +: DIGIT_W];
                r_staging[k] <= '0;
            end
        end else begin
            r_enable <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        if (!setMode) begin
                            r_digit  <= switches;
                            r_enable <= 1'b1;
                        end else if (unlocked) begin
                            r_state       <= S_PROGRAM;
                            r_programming <= 1'b1;
                            r_index       <= '0;
                        end
                    end
                end
                S_PROGRAM: begin
                    // Dropping setMode wins over a simultaneous press; the store is untouched.
                    if (!setMode) begin
                        r_state       <= S_IDLE;
                        r_programming <= 1'b0;
                        r_index       <= '0;
                    end else if (w_press) begin
                        r_staging[r_index] <= switches;
                        if (r_index == LAST_IDX) begin
                            for (int k = 0; k < PASSWORD_DIGITS - 1; k++) begin
                                r_store[k] <= r_staging[k];
                            end
                            r_store[LAST_IDX] <= switches;
                            r_done            <= 1'b1;
                            r_index           <= '0;
                            r_state           <= S_IDLE;
                            r_programming     <= 1'b0;
                        end else begin
                            r_index <= r_index + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_programming <= 1'b0;
                    r_index       <= '0;
                end
            endcase
        end
    end

    assign data         = r_store[address];
    assign digit        = r_digit;
    assign enable       = r_enable;
    assign programming  = r_programming;
    assign programIndex = r_index;
    assign programDone  = r_done;

endmodule
